// File: rtl/demux_dispatch8_pkg.sv
// demux_dispatch8_pkg: shared constants for the dispatch demultiplexer.
package demux_dispatch8_pkg;
    localparam int DISPATCH_CHANNELS_DEFAULT = 8;
    localparam int DISPATCH_SEL_W_DEFAULT    = 3;
    localparam int DISPATCH_DEPTH            = 2;
endpackage

// File: rtl/demux_dispatch8_if.sv
// demux_dispatch8_if: input stream plus packed per-channel output streams.
// Ports: in_valid/in_ready/in_data/in_sel (producer side),
//        out_bus/out_valid/out_ready (consumers), sel_err (drop pulse).
interface demux_dispatch8_if
    import demux_dispatch8_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = DISPATCH_CHANNELS_DEFAULT,
    parameter int SEL_W    = DISPATCH_SEL_W_DEFAULT
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic [CHANNELS*WIDTH-1:0] out_bus;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic                      sel_err;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_bus, out_valid, sel_err
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_bus, out_valid, sel_err
    );
endinterface

// File: rtl/demux_dispatch8_slot2.sv
// dispatch_slot2: 2-entry FIFO with the head always exposed.
// Ports: clk, reset (sync, active-high), flush (clear count), push/push_data,
//        pop (ignored when empty), head (entry 0), count (0..2).
module dispatch_slot2
    import demux_dispatch8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] r_mem [2];
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_base;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && (r_count < 2'(DISPATCH_DEPTH));
    // slot the new word lands in, after any same-cycle pop has shifted
    assign w_base = r_count - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_mem[0] <= (w_push && w_base == 2'd0) ? push_data : (w_pop ? r_mem[1] : r_mem[0]);
            r_mem[1] <= (w_push && w_base == 2'd1) ? push_data : r_mem[1];
        end
    end

    assign head  = r_mem[0];
    assign count = r_count;
endmodule

// File: rtl/demux_dispatch8.sv
// demux_dispatch8: steers one input word per cycle into per-channel 2-deep FIFOs.
// Ports: clk, reset (sync, active-high), flush (clear all channels),
//        bus (slave side of demux_dispatch8_if).
module demux_dispatch8
    import demux_dispatch8_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = DISPATCH_CHANNELS_DEFAULT,
    parameter int SEL_W    = DISPATCH_SEL_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    demux_dispatch8_if.slave bus
);
    localparam int NSEL = 1 << SEL_W;

    logic [CHANNELS-1:0] w_full;
    logic [NSEL-1:0]     w_full_x;
    logic                w_in_range;
    logic                w_accept;
    logic                r_sel_err;

    // out-of-range selects index zero padding, so they are always ready
    assign w_full_x     = NSEL'(w_full);
    assign w_in_range   = int'(bus.in_sel) < CHANNELS;
    assign bus.in_ready = !flush && !w_full_x[bus.in_sel];
    assign w_accept     = bus.in_valid && bus.in_ready;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [1:0]       w_count;
            logic [WIDTH-1:0] w_head;
            dispatch_slot2 #(.WIDTH(WIDTH)) u_slot (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .push      (w_accept && bus.in_sel == SEL_W'(i)),
                .push_data (bus.in_data),
                .pop       (bus.out_ready[i]),
                .head      (w_head),
                .count     (w_count)
            );
            assign w_full[i]        = w_count == 2'd2;
            assign bus.out_valid[i] = w_count != 2'd0;
            // channel 0 in the most significant slice
            assign bus.out_bus[(CHANNELS-1-i)*WIDTH +: WIDTH] = w_head;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            r_sel_err <= 1'b0;
        else
            r_sel_err <= w_accept && !w_in_range;
    end

    assign bus.sel_err = r_sel_err;
endmodule

// File: tb/tb_demux_dispatch8.sv
module tb_demux_dispatch8;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    demux_dispatch8_if #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) b8 ();
    demux_dispatch8_if #(.WIDTH(32), .CHANNELS(6), .SEL_W(3)) b6 ();

    demux_dispatch8 u8 (.clk(clk), .reset(reset), .flush(flush), .bus(b8));
    demux_dispatch8 #(.WIDTH(32), .CHANNELS(6), .SEL_W(3)) u6 (.clk(clk), .reset(reset), .flush(flush), .bus(b6));

    int checks = 0;
    int errors = 0;
    int nch [2] = '{8, 6};
    logic [31:0] mq [2][8][$];
    logic exp_err [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready(int k, logic [2:0] s, logic fl);
        return !fl && (int'(s) >= nch[k] || mq[k][s].size() < 2);
    endfunction

    function automatic logic dut_valid(int k, int c);
        return k == 0 ? b8.out_valid[c] : b6.out_valid[c];
    endfunction

    function automatic logic [31:0] dut_head(int k, int c);
        return k == 0 ? b8.out_bus[(7-c)*32 +: 32] : b6.out_bus[(5-c)*32 +: 32];
    endfunction

    function automatic logic dut_ready(int k);
        return k == 0 ? b8.in_ready : b6.in_ready;
    endfunction

    function automatic logic dut_err(int k);
        return k == 0 ? b8.sel_err : b6.sel_err;
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < nch[k]; c++) begin
                chk($sformatf("valid k%0d c%0d", k, c), 64'(dut_valid(k, c)), 64'(mq[k][c].size() != 0));
                if (mq[k][c].size() != 0)
                    chk($sformatf("head k%0d c%0d", k, c), 64'(dut_head(k, c)), 64'(mq[k][c][0]));
            end
            chk($sformatf("sel_err k%0d", k), 64'(dut_err(k)), 64'(exp_err[k]));
        end
    endtask

    task automatic step(input logic v, input logic [2:0] s, input logic [31:0] d,
                        input logic [7:0] r8, input logic [5:0] r6, input logic fl, input logic rs);
        logic acc [2];
        reset = rs;
        flush = fl;
        b8.in_valid = v;  b6.in_valid = v;
        b8.in_sel = s;    b6.in_sel = s;
        b8.in_data = d;   b6.in_data = d;
        b8.out_ready = r8;
        b6.out_ready = r6;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rs) chk($sformatf("in_ready k%0d", k), 64'(dut_ready(k)), 64'(exp_ready(k, s, fl)));
            acc[k] = v && exp_ready(k, s, fl);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rs || fl) begin
                for (int c = 0; c < 8; c++) mq[k][c].delete();
                exp_err[k] = 1'b0;
            end else begin
                for (int c = 0; c < nch[k]; c++)
                    if ((k == 0 ? r8[c] : r6[c]) && mq[k][c].size() != 0) void'(mq[k][c].pop_front());
                if (acc[k] && int'(s) < nch[k]) mq[k][s].push_back(d);
                exp_err[k] = acc[k] && int'(s) >= nch[k];
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        step(1'b0, 3'd0, 32'd0, 8'hFF, 6'h3F, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 8'hFF, 6'h3F, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) exp_err[k] = 1'b0;
        step(1'b0, 3'd0, 32'd0, 8'h00, 6'h00, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 8'h00, 6'h00, 1'b0, 1'b1);
        chk("rst out_valid", 64'(b8.out_valid), 64'h00);
        chk("rst out_bus zero", 64'(b8.out_bus == '0), 64'd1);
        chk("rst sel_err", 64'(b8.sel_err), 64'd0);
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 3'(s), 32'd0, 8'h00, 6'h00, 1'b0, 1'b0);
            chk($sformatf("rst in_ready sel%0d", s), 64'(b8.in_ready), 64'd1);
        end

        step(1'b1, 3'd5, 32'hDEAD_BEEF, 8'h00, 6'h00, 1'b0, 1'b0);
        chk("route valid", 64'(b8.out_valid), 64'h20);
        chk("route slice5", 64'(b8.out_bus[2*32 +: 32]), 64'hDEAD_BEEF);
        chk("route slice0 untouched", 64'(b8.out_bus[7*32 +: 32]), 64'h0);
        drain();

        step(1'b1, 3'd3, 32'h1, 8'h00, 6'h00, 1'b0, 1'b0);
        step(1'b1, 3'd3, 32'h2, 8'h00, 6'h00, 1'b0, 1'b0);
        step(1'b0, 3'd3, 32'h0, 8'h00, 6'h00, 1'b0, 1'b0);
        chk("full ch3 not ready", 64'(b8.in_ready), 64'd0);
        step(1'b0, 3'd2, 32'h0, 8'h00, 6'h00, 1'b0, 1'b0);
        chk("ch2 still ready", 64'(b8.in_ready), 64'd1);
        chk("ch3 head first", 64'(b8.out_bus[4*32 +: 32]), 64'h1);
        step(1'b0, 3'd2, 32'h0, 8'h08, 6'h08, 1'b0, 1'b0);
        chk("ch3 head second", 64'(b8.out_bus[4*32 +: 32]), 64'h2);
        step(1'b0, 3'd2, 32'h0, 8'h08, 6'h08, 1'b0, 1'b0);
        chk("ch3 empty", 64'(b8.out_valid[3]), 64'd0);

        step(1'b1, 3'd0, 32'hA, 8'h00, 6'h00, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'hB, 8'h01, 6'h01, 1'b0, 1'b0);
        chk("stream valid", 64'(b8.out_valid), 64'h01);
        chk("stream head", 64'(b8.out_bus[7*32 +: 32]), 64'hB);
        drain();

        step(1'b1, 3'd7, 32'hC0DE, 8'h00, 6'h00, 1'b0, 1'b0);
        chk("oor sel_err", 64'(b6.sel_err), 64'd1);
        chk("oor out_valid", 64'(b6.out_valid), 64'h00);
        step(1'b0, 3'd7, 32'h0, 8'h00, 6'h00, 1'b0, 1'b0);
        chk("oor sel_err pulse", 64'(b6.sel_err), 64'd0);
        chk("oor in_ready", 64'(b6.in_ready), 64'd1);
        drain();

        for (int r = 0; r < 2; r++) begin
            step(1'b1, 3'd1, 32'h11, 8'h00, 6'h00, 1'b0, 1'b0);
            step(1'b1, 3'd1, 32'h12, 8'h00, 6'h00, 1'b0, 1'b0);
            step(1'b1, 3'd4, 32'h41, 8'h00, 6'h00, 1'b0, 1'b0);
            step(1'b1, 3'd4, 32'h42, 8'h00, 6'h00, 1'b0, 1'b0);
            chk("pre-clear valid", 64'(b8.out_valid), 64'h12);
            if (r == 0) begin
                flush = 1'b1;
                b8.in_sel = 3'd2;
                #1;
                chk("flush in_ready", 64'(b8.in_ready), 64'd0);
                step(1'b1, 3'd2, 32'h99, 8'h00, 6'h00, 1'b1, 1'b0);
            end else begin
                step(1'b1, 3'd7, 32'h99, 8'h00, 6'h00, 1'b0, 1'b1);
            end
            chk("clear out_valid", 64'(b8.out_valid), 64'h00);
            chk("clear sel_err", 64'(b6.sel_err), 64'd0);
        end

        for (int n = 0; n < 3000; n++)
            step(($urandom % 4) != 0, 3'($urandom % 8), $urandom, 8'($urandom), 6'($urandom),
                 ($urandom % 64) == 0, ($urandom % 200) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
